// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file, field split, early branch/jump
// resolution, registered ID/EX pipeline register and a syscall handshake
// towards the host.
// Optional feature macro: DECODE_WB_BYPASS_EN (write-through register reads).
// Handshake: syscall_valid rises with the request and stays high, with
// syscall_funct/syscall_param1 stable, until the edge on which syscall_ready=1
// is seen; a transfer happens on any edge with syscall_valid && syscall_ready.
module decode_issue_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_REGS          = 32,
  parameter int LINK_REG          = 31,
  parameter int SYSCALL_FUNCT_REG = 2,
  parameter int SYSCALL_PARAM_REG = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [31:0]           instruction,
  input  logic [31:0]           pc_plus_four,
  output logic                  instr_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  reg_write_W,
  input  logic [4:0]            writeback_id,
  input  logic [DATA_WIDTH-1:0] writeback_value,
  output logic                  pc_src,
  output logic [31:0]           jump_address,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_rs_value,
  output logic [DATA_WIDTH-1:0] ex_rt_value,
  output logic [DATA_WIDTH-1:0] ex_immediate,
  output logic [4:0]            ex_rs_id,
  output logic [4:0]            ex_rt_id,
  output logic [4:0]            ex_rd_id,
  output logic [4:0]            ex_shamt,
  output logic [5:0]            ex_opcode,
  output logic [5:0]            ex_funct,
  output logic [31:0]           ex_link_value,
  output logic                  syscall_valid,
  input  logic                  syscall_ready,
  output logic [DATA_WIDTH-1:0] syscall_funct,
  output logic [DATA_WIDTH-1:0] syscall_param1,
  output logic                  dbg_sys_wait
);

  typedef enum logic {IDLE = 1'b0, SYS_WAIT = 1'b1} state_t;

  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] view [NUM_REGS];

  logic [5:0] opcode, funct;
  logic [4:0] rs_id, rt_id, rd_id, shamt;
  logic [15:0] imm16;
  logic [DATA_WIDTH-1:0] rs_val, rt_val, sys_f_val, sys_p_val, imm_ext;
  logic accept, is_syscall;

  logic                  ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0] ex_rs_value_q, ex_rs_value_d, ex_rt_value_q, ex_rt_value_d;
  logic [DATA_WIDTH-1:0] ex_immediate_q, ex_immediate_d;
  logic [4:0]            ex_rs_id_q, ex_rs_id_d, ex_rt_id_q, ex_rt_id_d;
  logic [4:0]            ex_rd_id_q, ex_rd_id_d, ex_shamt_q, ex_shamt_d;
  logic [5:0]            ex_opcode_q, ex_opcode_d, ex_funct_q, ex_funct_d;
  logic [31:0]           ex_link_value_q, ex_link_value_d;
  logic                  syscall_valid_q, syscall_valid_d;
  logic [DATA_WIDTH-1:0] syscall_funct_q, syscall_funct_d, syscall_param1_q, syscall_param1_d;

  assign opcode = instruction[31:26];
  assign rs_id  = instruction[25:21];
  assign rt_id  = instruction[20:16];
  assign rd_id  = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];
  assign imm16  = instruction[15:0];

  assign instr_ready = (state_q == IDLE) && !stall;
  assign accept      = instr_valid && instr_ready;
  assign is_syscall  = (opcode == 6'h00) && (funct == 6'h0C);
  assign dbg_sys_wait = (state_q == SYS_WAIT);

  // Register file write port; register 0 and out-of-range ids never change.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (reg_write_W && writeback_id != 5'd0) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (writeback_id == 5'(i)) regs_d[i] = writeback_value;
    end
  end

  // Read view of the register file as seen by decode this cycle.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      view[i] = regs_q[i];
`ifdef DECODE_WB_BYPASS_EN
      if (reg_write_W && writeback_id == 5'(i)) view[i] = writeback_value;
`endif
    end
    view[0] = '0;
  end

  // Read ports; ids that match no implemented register read as 0.
  always_comb begin
    rs_val    = '0;
    rt_val    = '0;
    sys_f_val = '0;
    sys_p_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs_id == 5'(i)) rs_val = view[i];
      if (rt_id == 5'(i)) rt_val = view[i];
      if (SYSCALL_FUNCT_REG == i) sys_f_val = view[i];
      if (SYSCALL_PARAM_REG == i) sys_p_val = view[i];
    end
  end

  // Immediate extension: logical immediates are zero-extended.
  always_comb begin
    if (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
      imm_ext = {{(DATA_WIDTH-16){1'b0}}, imm16};
    else
      imm_ext = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
  end

  // Early redirect for taken branches and jumps on an accepted instruction.
  always_comb begin
    pc_src       = 1'b0;
    jump_address = 32'd0;
    if (accept) begin
      case (opcode)
        6'h04: if (rs_val == rt_val) begin
          pc_src       = 1'b1;
          jump_address = pc_plus_four + {{14{imm16[15]}}, imm16, 2'b00};
        end
        6'h05: if (rs_val != rt_val) begin
          pc_src       = 1'b1;
          jump_address = pc_plus_four + {{14{imm16[15]}}, imm16, 2'b00};
        end
        6'h02, 6'h03: begin
          pc_src       = 1'b1;
          jump_address = {pc_plus_four[31:28], instruction[25:0], 2'b00};
        end
        default: ;
      endcase
    end
  end

  // ID/EX next value: flush beats stall, stall holds, otherwise load or bubble.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_rs_value_d   = ex_rs_value_q;
    ex_rt_value_d   = ex_rt_value_q;
    ex_immediate_d  = ex_immediate_q;
    ex_rs_id_d      = ex_rs_id_q;
    ex_rt_id_d      = ex_rt_id_q;
    ex_rd_id_d      = ex_rd_id_q;
    ex_shamt_d      = ex_shamt_q;
    ex_opcode_d     = ex_opcode_q;
    ex_funct_d      = ex_funct_q;
    ex_link_value_d = ex_link_value_q;
    if (!stall || flush) begin
      ex_valid_d      = 1'b0;
      ex_rs_value_d   = '0;
      ex_rt_value_d   = '0;
      ex_immediate_d  = '0;
      ex_rs_id_d      = '0;
      ex_rt_id_d      = '0;
      ex_rd_id_d      = '0;
      ex_shamt_d      = '0;
      ex_opcode_d     = '0;
      ex_funct_d      = '0;
      ex_link_value_d = '0;
      if (!flush && accept && !is_syscall) begin
        ex_valid_d      = 1'b1;
        ex_rs_value_d   = rs_val;
        ex_rt_value_d   = rt_val;
        ex_immediate_d  = imm_ext;
        ex_rs_id_d      = rs_id;
        ex_rt_id_d      = rt_id;
        ex_rd_id_d      = (opcode == 6'h03) ? 5'(LINK_REG) : rd_id;
        ex_shamt_d      = shamt;
        ex_opcode_d     = opcode;
        ex_funct_d      = funct;
        ex_link_value_d = (opcode == 6'h03) ? pc_plus_four + 32'd4 : 32'd0;
      end
    end
  end

  // Syscall FSM: capture the request on accept, release on host ready.
  always_comb begin
    state_d          = state_q;
    syscall_valid_d  = syscall_valid_q;
    syscall_funct_d  = syscall_funct_q;
    syscall_param1_d = syscall_param1_q;
    case (state_q)
      IDLE: if (accept && is_syscall) begin
        state_d          = SYS_WAIT;
        syscall_valid_d  = 1'b1;
        syscall_funct_d  = sys_f_val;
        syscall_param1_d = sys_p_val;
      end
      SYS_WAIT: if (syscall_ready) begin
        state_d         = IDLE;
        syscall_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      ex_valid_q       <= 1'b0;
      ex_rs_value_q    <= '0;
      ex_rt_value_q    <= '0;
      ex_immediate_q   <= '0;
      ex_rs_id_q       <= '0;
      ex_rt_id_q       <= '0;
      ex_rd_id_q       <= '0;
      ex_shamt_q       <= '0;
      ex_opcode_q      <= '0;
      ex_funct_q       <= '0;
      ex_link_value_q  <= '0;
      syscall_valid_q  <= 1'b0;
      syscall_funct_q  <= '0;
      syscall_param1_q <= '0;
    end else begin
      state_q          <= state_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      ex_valid_q       <= ex_valid_d;
      ex_rs_value_q    <= ex_rs_value_d;
      ex_rt_value_q    <= ex_rt_value_d;
      ex_immediate_q   <= ex_immediate_d;
      ex_rs_id_q       <= ex_rs_id_d;
      ex_rt_id_q       <= ex_rt_id_d;
      ex_rd_id_q       <= ex_rd_id_d;
      ex_shamt_q       <= ex_shamt_d;
      ex_opcode_q      <= ex_opcode_d;
      ex_funct_q       <= ex_funct_d;
      ex_link_value_q  <= ex_link_value_d;
      syscall_valid_q  <= syscall_valid_d;
      syscall_funct_q  <= syscall_funct_d;
      syscall_param1_q <= syscall_param1_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_rs_value    = ex_rs_value_q;
  assign ex_rt_value    = ex_rt_value_q;
  assign ex_immediate   = ex_immediate_q;
  assign ex_rs_id       = ex_rs_id_q;
  assign ex_rt_id       = ex_rt_id_q;
  assign ex_rd_id       = ex_rd_id_q;
  assign ex_shamt       = ex_shamt_q;
  assign ex_opcode      = ex_opcode_q;
  assign ex_funct       = ex_funct_q;
  assign ex_link_value  = ex_link_value_q;
  assign syscall_valid  = syscall_valid_q;
  assign syscall_funct  = syscall_funct_q;
  assign syscall_param1 = syscall_param1_q;

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
Parametrised successor to the single-cycle decode stage. It holds the register file, splits instruction fields, resolves branches and jumps early, and drives a registered ID/EX pipeline register with stall, flush and valid tracking. A syscall is not issued downstream; the block hands it to the host through a valid/ready handshake and holds the pipeline until the host accepts it.

Parameters:
DATA_WIDTH, 32, width of register file entries, operand values and immediates; must be 32 or more.
NUM_REGS, 32, number of architectural registers, 2..32. Reads of ids >= NUM_REGS return 0. Writes to those ids are ignored.
LINK_REG, 31, destination register for jal.
SYSCALL_FUNCT_REG, 2, register sampled as the syscall function code.
SYSCALL_PARAM_REG, 4, register sampled as the syscall first parameter.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
instr_valid  in  1  fetch presents an instruction
instruction  in  32  instruction word
pc_plus_four  in  32  PC of instruction + 4
instr_ready  out  1  comb; (state==IDLE) && !stall
stall  in  1  hazard unit: hold ID/EX register, accept nothing
flush  in  1  hazard unit: load a bubble into ID/EX
reg_write_W  in  1  writeback enable
writeback_id  in  5  writeback destination
writeback_value  in  DATA_WIDTH  writeback data
pc_src  out  1  comb; taken branch or jump on an accepted instruction
jump_address  out  32  comb; redirect target (valid when pc_src=1)
ex_valid  out  1  reg; ID/EX holds a real instruction
ex_rs_value, ex_rt_value  out  DATA_WIDTH  reg; operand values
ex_immediate  out  DATA_WIDTH  reg; extended immediate
ex_rs_id, ex_rt_id, ex_rd_id, ex_shamt  out  5 each  reg; instruction fields (ex_rd_id = LINK_REG for jal)
ex_opcode, ex_funct  out  6 each  reg
ex_link_value  out  32  reg; pc_plus_four+4 for jal, otherwise 0
syscall_valid  out  1  reg; syscall request pending
syscall_ready  in  1  host accepts the request
syscall_funct, syscall_param1  out  DATA_WIDTH  reg; sampled register values

Behaviour:
- accept = instr_valid && instr_ready. A syscall is opcode 0 with funct 0x0C.
- Register file:
  - Write on a clock edge when reg_write_W=1, writeback_id!=0 and writeback_id<NUM_REGS.
  - Register 0 always reads 0.
  - Reset clears all entries to 0.
- Immediate:
  - Zero-extended for opcodes 0x0C, 0x0D and 0x0E.
  - Sign-extended to DATA_WIDTH for all other opcodes.
- Branch and jump redirect, meaningful only when accept=1:
  - beq (0x04) is taken when rs==rt; bne (0x05) is taken when rs!=rt. Compare the full DATA_WIDTH values.
  - Branch target = pc_plus_four + (sext16(imm)<<2), wrapping modulo 2^32.
  - j (0x02) and jal (0x03) always redirect to {pc_plus_four[31:28], instr[25:0], 2'b00}.
  - When accept=0, pc_src=0 and jump_address=0.
- ID/EX register update, in priority order:
  1. reset: all ex_* outputs = 0, ex_valid = 0.
  2. flush: ex_valid = 0, other fields = 0. Flush wins over stall.
  3. stall: hold all fields.
  4. accept of a non-syscall instruction: load the decoded fields, ex_valid = 1.
  5. Otherwise (no valid instruction, or a syscall, or state SYS_WAIT): load a bubble (ex_valid = 0).
- Latency: one cycle from accept to ex_* outputs.
- Syscall FSM, states IDLE and SYS_WAIT. Reset forces IDLE with syscall_valid = 0 and syscall_funct = syscall_param1 = 0.
  - IDLE to SYS_WAIT on accept of a syscall. On that edge, syscall_funct and syscall_param1 capture the (bypassed) values of SYSCALL_FUNCT_REG and SYSCALL_PARAM_REG, and syscall_valid goes to 1.
  - SYS_WAIT holds while syscall_ready=0. instr_ready=0 throughout, so fetch must keep the next instruction stable.
  - SYS_WAIT to IDLE on the edge where syscall_ready=1. syscall_valid falls on that edge, and the next instruction can be accepted in the following cycle.
  - syscall_ready is ignored in IDLE.
  - Reset in SYS_WAIT aborts the request: syscall_valid = 0 on the next edge and the state returns to IDLE.
  - flush does not cancel a pending syscall.

Optional Feature:
DECODE_WB_BYPASS_EN
- Defined: a read of register r in the same cycle as a write to r returns writeback_value (write-through). This applies to the rs and rt reads, the branch comparison and the syscall sampling.
- Undefined: reads return the stored value, i.e. the old value in that cycle. The hazard unit must then stall one extra cycle on a W-to-D dependency.

Test Plan:
1. Reset: write 0x5 to r8, apply reset for one cycle -> next cycle, reading r8 gives 0, ex_valid=0, syscall_valid=0.
2. Write 0xDEAD_BEEF to r8, then accept addi r9,r8,-1 (0x2109FFFF) -> one cycle later ex_valid=1, ex_rs_value=0xDEADBEEF, ex_immediate=0xFFFFFFFF. Repeat with ori -> ex_immediate=0x0000FFFF.
3. beq r1,r2,+4 with pc_plus_four=0x100: with r1==r2 -> pc_src=1, jump_address=0x110; with r1!=r2 -> pc_src=0. jal with pc_plus_four=0x0040_0004 -> ex_rd_id=31, ex_link_value=0x0040_0008.
4. Stall held 2 cycles, then flush asserted together with stall -> ex_* fields hold during the stall, ex_valid=0 after the flush edge, instr_ready=0 while stall=1.
5. Syscall with r2=10, r4=7, and syscall_ready held low 3 cycles -> syscall_valid=1, syscall_funct=10, syscall_param1=7, instr_ready=0, ex_valid=0. Raise syscall_ready -> syscall_valid=0 and instr_ready=1 the next cycle. A reset during SYS_WAIT -> state IDLE, syscall_valid=0.
6. Write r5=3 while reading r5 in the same cycle -> with DECODE_WB_BYPASS_EN defined, ex_rs_value=3; undefined, ex_rs_value=the old value.
